// File: rtl/student_iis_pkg.sv
// Shared types and default geometry for the I2S DAC timing path.
package student_iis_pkg;

  localparam int DEF_DATA_SIZE     = 16;
  localparam int DEF_BCLK_HALF_DIV = 4;
  localparam int DEF_BITS_PER_CH   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_DATA_SIZE-1:0] l;
    logic [DEF_DATA_SIZE-1:0] r;
  } stereo_t;

endpackage

// File: rtl/student_iis_clkgen.sv
// BCLK/LRCLK generator with registered edge strobes aligned to the new clock levels.
// frame_evt_o is combinational: high in the cycle whose closing edge starts a new frame.
module student_iis_clkgen #(
  parameter int BCLK_HALF_DIV = 4,
  parameter int BITS_PER_CH   = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic start_i,
  output logic bclk_o,
  output logic lrclk_o,
  output logic bclk_fall_o,
  output logic lrclk_rise_o,
  output logic lrclk_fall_o,
  output logic frame_evt_o
);
  localparam int DIV_W = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
  localparam int BIT_W = (BITS_PER_CH > 1) ? $clog2(BITS_PER_CH) : 1;

  logic [DIV_W-1:0] r_div;
  logic [BIT_W-1:0] r_bit;
  logic r_bclk, r_lrclk, r_bclk_fall, r_lrclk_rise, r_lrclk_fall;
  logic w_div_tc, w_fall, w_wrap;

  assign w_div_tc    = (r_div == DIV_W'(BCLK_HALF_DIV - 1));
  assign w_fall      = run_i && w_div_tc && r_bclk;
  assign w_wrap      = (r_bit == BIT_W'(BITS_PER_CH - 1));
  assign frame_evt_o = w_fall && w_wrap && r_lrclk;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_div        <= '0;
      r_bit        <= '0;
      r_bclk       <= 1'b0;
      r_lrclk      <= 1'b0;
      r_bclk_fall  <= 1'b0;
      r_lrclk_rise <= 1'b0;
      r_lrclk_fall <= 1'b0;
    end else begin
      r_bclk_fall  <= 1'b0;
      r_lrclk_rise <= 1'b0;
      r_lrclk_fall <= 1'b0;
      if (run_i) begin
        if (w_div_tc) begin
          r_div  <= '0;
          r_bclk <= ~r_bclk;
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
        // LRCLK only ever moves on a BCLK fall, so its strobes coincide with bclk_fall
        if (w_fall) begin
          r_bclk_fall <= 1'b1;
          if (w_wrap) begin
            r_bit        <= '0;
            r_lrclk      <= ~r_lrclk;
            r_lrclk_rise <= ~r_lrclk;
            r_lrclk_fall <= r_lrclk;
          end else begin
            r_bit <= r_bit + BIT_W'(1);
          end
        end
      end else begin
        r_div        <= '0;
        r_bit        <= '0;
        r_bclk       <= 1'b0;
        r_lrclk      <= 1'b0;
        r_lrclk_fall <= start_i;
      end
    end
  end

  assign bclk_o       = r_bclk;
  assign lrclk_o      = r_lrclk;
  assign bclk_fall_o  = r_bclk_fall;
  assign lrclk_rise_o = r_lrclk_rise;
  assign lrclk_fall_o = r_lrclk_fall;

endmodule

// File: rtl/student_iis_frame_ctrl.sv
// I2S frame controller: run FSM, one-pair pending slot, frame-aligned output words.
// Each frame start loads the pending pair, or mutes and records an underrun if it is empty.
module student_iis_frame_ctrl
  import student_iis_pkg::*;
#(
  parameter int DATA_SIZE      = DEF_DATA_SIZE,
  parameter int BCLK_HALF_DIV  = DEF_BCLK_HALF_DIV,
  parameter int BITS_PER_CH    = DEF_BITS_PER_CH,
  parameter int UNDERRUN_CNT_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [DATA_SIZE-1:0]      data_l_i,
  input  logic [DATA_SIZE-1:0]      data_r_i,
  output logic [DATA_SIZE-1:0]      data_l_o,
  output logic [DATA_SIZE-1:0]      data_r_o,
  output logic                      bclk_o,
  output logic                      lrclk_o,
  output logic                      bclk_fall_o,
  output logic                      lrclk_rise_o,
  output logic                      lrclk_fall_o,
  output logic                      underrun_o,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt_o,
  input  logic                      clr_underrun_i,
  output logic [15:0]               frame_cnt_o
);
  typedef struct packed {
    logic [DATA_SIZE-1:0] l;
    logic [DATA_SIZE-1:0] r;
  } pair_t;

  state_t r_state, w_state_nxt;
  logic   w_start, w_run, w_frame_evt, w_load, w_accept;
  pair_t  r_pend, r_data;
  logic   r_pend_vld, r_underrun;
  logic [UNDERRUN_CNT_W-1:0] r_ur_cnt;
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = START;
      START:   w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
    if (!enable_i) w_state_nxt = IDLE;
  end

  always_comb begin
    w_start = 1'b0;
    w_run   = 1'b0;
    case (r_state)
      START:   w_start = enable_i;
      RUN:     w_run   = enable_i;
      default: ;
    endcase
  end

  student_iis_clkgen #(
    .BCLK_HALF_DIV(BCLK_HALF_DIV),
    .BITS_PER_CH  (BITS_PER_CH)
  ) u_clkgen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .run_i       (w_run),
    .start_i     (w_start),
    .bclk_o      (bclk_o),
    .lrclk_o     (lrclk_o),
    .bclk_fall_o (bclk_fall_o),
    .lrclk_rise_o(lrclk_rise_o),
    .lrclk_fall_o(lrclk_fall_o),
    .frame_evt_o (w_frame_evt)
  );

  // A slot being drained this cycle can be refilled in the same cycle
  assign w_load   = w_start || w_frame_evt;
  assign ready_o  = !r_pend_vld || w_load;
  assign w_accept = valid_i && ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
    end else if (w_accept) begin
      r_pend     <= '{l: data_l_i, r: data_r_i};
      r_pend_vld <= 1'b1;
    end else if (w_load) begin
      r_pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data      <= '0;
      r_frame_cnt <= '0;
    end else if (w_load) begin
      r_data      <= r_pend_vld ? r_pend : '0;
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_underrun <= 1'b0;
      r_ur_cnt   <= '0;
    end else if (clr_underrun_i) begin
      r_underrun <= 1'b0;
      r_ur_cnt   <= '0;
    end else if (w_load && !r_pend_vld) begin
      r_underrun <= 1'b1;
      if (r_ur_cnt != '1) r_ur_cnt <= r_ur_cnt + UNDERRUN_CNT_W'(1);
    end
  end

  assign data_l_o       = r_data.l;
  assign data_r_o       = r_data.r;
  assign underrun_o     = r_underrun;
  assign underrun_cnt_o = r_ur_cnt;
  assign frame_cnt_o    = r_frame_cnt;

endmodule

// File: tb/tb_student_iis_frame_ctrl.sv
// Bench for student_iis_frame_ctrl: reference model tracks time since frame start
// and derives clock levels, strobes and frame loads from that count arithmetically.
module tb_student_iis_frame_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        clr_underrun_i = 1'b0;
  logic [15:0] data_l_i = '0;
  logic [15:0] data_r_i = '0;
  logic        ready_o, bclk_o, lrclk_o, bclk_fall_o, lrclk_rise_o, lrclk_fall_o, underrun_o;
  logic [15:0] data_l_o, data_r_o, frame_cnt_o;
  logic [7:0]  underrun_cnt_o;

  int checks = 0;
  int errors = 0;

  // model: phase 0 idle, 1 start, 2 run; m_t = cycles since the frame-start edge
  int          m_state, m_t, m_uc, m_fc;
  bit          m_pv, m_ur;
  logic [15:0] m_pl, m_pr, m_dl, m_dr;

  student_iis_frame_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_l_i(data_l_i), .data_r_i(data_r_i),
    .data_l_o(data_l_o), .data_r_o(data_r_o), .bclk_o(bclk_o), .lrclk_o(lrclk_o),
    .bclk_fall_o(bclk_fall_o), .lrclk_rise_o(lrclk_rise_o), .lrclk_fall_o(lrclk_fall_o),
    .underrun_o(underrun_o), .underrun_cnt_o(underrun_cnt_o),
    .clr_underrun_i(clr_underrun_i), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  wire [61:0] dut_vec = {bclk_o, lrclk_o, bclk_fall_o, lrclk_rise_o, lrclk_fall_o,
                         data_l_o, data_r_o, underrun_o, underrun_cnt_o, frame_cnt_o};

  function automatic bit m_load_now();
    return enable_i && (m_state == 1 || (m_state == 2 && (m_t % 512) == 511));
  endfunction

  function automatic logic [4:0] exp_clk();
    logic [4:0] v;
    v = '0;
    if (m_state == 2) begin
      v[4] = ((m_t / 4) % 2) == 1;
      v[3] = ((m_t / 256) % 2) == 1;
      v[2] = (m_t > 0) && ((m_t % 8) == 0);
      v[1] = (m_t % 512) == 256;
      v[0] = (m_t % 512) == 0;
    end
    return v;
  endfunction

  function automatic logic [61:0] exp_vec();
    return {exp_clk(), m_dl, m_dr, m_ur, 8'(m_uc), 16'(m_fc)};
  endfunction

  task automatic step(output bit acc, output bit load);
    bit en;
    en   = enable_i;
    load = m_load_now();
    acc  = valid_i && (!m_pv || load);
    if (load) begin
      m_fc = (m_fc + 1) % 65536;
      if (m_pv) begin
        m_dl = m_pl; m_dr = m_pr;
      end else begin
        m_dl = '0; m_dr = '0; m_ur = 1'b1;
        if (m_uc < 255) m_uc++;
      end
    end
    if (clr_underrun_i) begin
      m_ur = 1'b0; m_uc = 0;
    end
    if (acc) begin
      m_pl = data_l_i; m_pr = data_r_i; m_pv = 1'b1;
    end else if (load) begin
      m_pv = 1'b0;
    end
    if (!en) begin
      m_state = 0; m_t = 0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      m_state = 2; m_t = 0;
    end else begin
      m_t++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; enable_i = 1'b0; valid_i = 1'b0; clr_underrun_i = 1'b0;
    data_l_i = '0; data_r_i = '0;
    m_state = 0; m_t = 0; m_uc = 0; m_fc = 0; m_pv = 1'b0; m_ur = 1'b0;
    m_pl = '0; m_pr = '0; m_dl = '0; m_dr = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", dut_vec); end
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
  endtask

  task automatic test_idle_enable();
    bit a, l;
    int n_bf, n_lr;
    logic prev_lr;
    enable_i = 1'b1;
    step(a, l); step(a, l);
    checks++;
    if ({lrclk_fall_o, underrun_o, underrun_cnt_o, data_l_o, data_r_o, frame_cnt_o} !==
        {1'b1, 1'b1, 8'd1, 16'd0, 16'd0, 16'd1}) begin
      errors++;
      $display("FAIL start_underrun got lf=%b ur=%b cnt=%0d l=%h r=%h fc=%0d exp 1 1 1 0 0 1",
               lrclk_fall_o, underrun_o, underrun_cnt_o, data_l_o, data_r_o, frame_cnt_o);
    end
    n_bf = 0; n_lr = 0; prev_lr = lrclk_o;
    for (int c = 0; c < 1100; c++) begin
      #1;
      checks++;
      if (ready_o !== (!m_pv || m_load_now())) begin
        errors++; $display("FAIL idle_ready t=%0d got=%b", m_t, ready_o);
      end
      step(a, l);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL idle_vec t=%0d got=%h exp=%h", m_t, dut_vec, exp_vec());
      end
      if (bclk_fall_o === 1'b1) n_bf++;
      if (lrclk_o !== prev_lr) n_lr++;
      prev_lr = lrclk_o;
    end
    checks++;
    if (n_bf != 137) begin errors++; $display("FAIL bclk_falls got=%0d exp=137", n_bf); end
    checks++;
    if (n_lr != 4) begin errors++; $display("FAIL lrclk_toggles got=%0d exp=4", n_lr); end
  endtask

  task automatic test_preload();
    bit a, l;
    do_reset();
    valid_i = 1'b1; data_l_i = 16'h1234; data_r_i = 16'h8001;
    step(a, l);
    valid_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL preload_full_ready got=%b exp=0", ready_o); end
    enable_i = 1'b1;
    step(a, l);
    #1;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL start_ready got=%b exp=1", ready_o); end
    step(a, l);
    checks++;
    if ({data_l_o, data_r_o, frame_cnt_o, lrclk_fall_o, underrun_o, ready_o} !==
        {16'h1234, 16'h8001, 16'd1, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL preload_load got l=%h r=%h fc=%0d lf=%b ur=%b rdy=%b", data_l_o, data_r_o,
               frame_cnt_o, lrclk_fall_o, underrun_o, ready_o);
    end
    for (int c = 0; c < 256; c++) begin
      step(a, l);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL preload_vec t=%0d got=%h exp=%h", m_t, dut_vec, exp_vec());
      end
    end
    checks++;
    if ({lrclk_rise_o, data_r_o} !== {1'b1, 16'h8001}) begin
      errors++; $display("FAIL rise_hold got rise=%b r=%h exp 1 8001", lrclk_rise_o, data_r_o);
    end
  endtask

  task automatic test_back_to_back();
    bit a, l, dut_acc;
    int k, n_acc;
    do_reset();
    k = 0; n_acc = 0;
    valid_i = 1'b1; data_l_i = 16'(k); data_r_i = 16'($urandom);
    enable_i = 1'b1;
    for (int c = 0; c < 2 + 9 * 512; c++) begin
      #1;
      dut_acc = valid_i && ready_o;
      checks++;
      if (ready_o !== (!m_pv || m_load_now())) begin
        errors++; $display("FAIL b2b_ready t=%0d got=%b", m_t, ready_o);
      end
      step(a, l);
      if (dut_acc) begin
        checks++;
        if (n_acc > 0 && !l) begin
          errors++; $display("FAIL b2b_accept_off_load t=%0d got=accept exp=no accept", m_t);
        end
        n_acc++;
      end
      if (a) begin
        k++; data_l_i = 16'(k); data_r_i = 16'($urandom);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL b2b_vec t=%0d got=%h exp=%h", m_t, dut_vec, exp_vec());
      end
    end
    checks++;
    if ({n_acc == 11, frame_cnt_o, underrun_o, data_l_o} !== {1'b1, 16'd10, 1'b0, 16'd9}) begin
      errors++;
      $display("FAIL b2b_summary got acc=%0d fc=%0d ur=%b l=%0d exp 11 10 0 9", n_acc, frame_cnt_o,
               underrun_o, data_l_o);
    end
    valid_i = 1'b0;
  endtask

  task automatic test_saturation();
    bit a, l;
    int e;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      enable_i = 1'b1;
      step(a, l); step(a, l);
      enable_i = 1'b0;
      step(a, l);
      e = (i + 1 > 255) ? 255 : i + 1;
      checks++;
      if (underrun_cnt_o !== 8'(e)) begin
        errors++; $display("FAIL sat_count i=%0d got=%0d exp=%0d", i, underrun_cnt_o, e);
      end
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL sat_vec got=%h exp=%h", dut_vec, exp_vec());
    end
    clr_underrun_i = 1'b1;
    step(a, l);
    clr_underrun_i = 1'b0;
    checks++;
    if ({underrun_o, underrun_cnt_o} !== 9'd0) begin
      errors++; $display("FAIL clr got ur=%b cnt=%0d exp 0 0", underrun_o, underrun_cnt_o);
    end
    enable_i = 1'b1;
    step(a, l);
    clr_underrun_i = 1'b1;
    step(a, l);
    clr_underrun_i = 1'b0;
    checks++;
    if ({underrun_o, underrun_cnt_o, frame_cnt_o} !== {1'b0, 8'd0, 16'd301}) begin
      errors++;
      $display("FAIL clr_wins got ur=%b cnt=%0d fc=%0d exp 0 0 301", underrun_o, underrun_cnt_o,
               frame_cnt_o);
    end
    enable_i = 1'b0;
    step(a, l);
  endtask

  task automatic test_enable_drop();
    bit a, l;
    do_reset();
    valid_i = 1'b1; data_l_i = 16'hAAAA; data_r_i = 16'h5555;
    step(a, l);
    valid_i = 1'b0; enable_i = 1'b1;
    step(a, l); step(a, l);
    valid_i = 1'b1; data_l_i = 16'hBEEF; data_r_i = 16'hCAFE;
    step(a, l);
    valid_i = 1'b0;
    while (m_t < 139) begin
      step(a, l);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL drop_vec t=%0d got=%h exp=%h", m_t, dut_vec, exp_vec());
      end
    end
    enable_i = 1'b0;
    step(a, l);
    #1;
    checks++;
    if ({bclk_o, lrclk_o, bclk_fall_o, lrclk_rise_o, lrclk_fall_o, data_l_o, ready_o} !==
        {5'b0, 16'hAAAA, 1'b0}) begin
      errors++;
      $display("FAIL drop_idle got clk=%b%b l=%h rdy=%b exp 00 aaaa 0", bclk_o, lrclk_o, data_l_o,
               ready_o);
    end
    repeat (5) step(a, l);
    enable_i = 1'b1;
    step(a, l); step(a, l);
    checks++;
    if ({lrclk_fall_o, data_l_o, data_r_o, frame_cnt_o} !== {1'b1, 16'hBEEF, 16'hCAFE, 16'd2}) begin
      errors++;
      $display("FAIL restart_load got lf=%b l=%h r=%h fc=%0d exp 1 beef cafe 2", lrclk_fall_o,
               data_l_o, data_r_o, frame_cnt_o);
    end
  endtask

  task automatic test_random();
    bit a, l;
    enable_i = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      valid_i        = ($urandom_range(0, 399) == 0);
      data_l_i       = 16'($urandom);
      data_r_i       = 16'($urandom);
      clr_underrun_i = ($urandom_range(0, 499) == 0);
      if (enable_i) enable_i = ($urandom_range(0, 1999) != 0);
      else          enable_i = ($urandom_range(0, 7) == 0);
      #1;
      checks++;
      if (ready_o !== (!m_pv || m_load_now())) begin
        errors++; $display("FAIL rand_ready c=%0d got=%b", c, ready_o);
      end
      step(a, l);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rand_vec c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
    end
    valid_i = 1'b0; clr_underrun_i = 1'b0;
  endtask

  task automatic test_async_reset();
    bit a, l;
    enable_i = 1'b1;
    repeat (300) step(a, l);
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    checks++;
    if (dut_vec !== '0) begin errors++; $display("FAIL async_reset_outputs got=%h exp=0", dut_vec); end
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL async_reset_ready got=%b exp=1", ready_o); end
    do_reset();
    enable_i = 1'b1;
    for (int c = 0; c < 600; c++) begin
      step(a, l);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL recover_vec t=%0d got=%h exp=%h", m_t, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_enable();
    test_preload();
    test_back_to_back();
    test_saturation();
    test_enable_drop();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
